// File: rtl/regfile_pkg.sv
// Shared defaults for the scoreboarded register file.
package regfile_pkg;

  localparam int BIT_SIZE_DEF = 32;
  localparam int ADDR_W_DEF   = 5;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-entry busy bits for outstanding multi-cycle producers, with a population
// count and a sticky error flag for refused reservations.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              resv_valid,
  input  logic [ADDR_W-1:0] resv_addr,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic              busy_1,
  output logic              busy_2,
  output logic              resv_stall,
  output logic [ADDR_W:0]   pending_cnt,
  output logic              resv_err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d, busy_wr;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             wr_eff, resv_eff, accept, refuse, clear;

  // A write retires the old producer before a same-cycle reservation is judged,
  // so write+reserve of one entry is accepted and leaves the count unchanged.
  always_comb begin
    wr_eff   = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    resv_eff = resv_valid && !((ZERO_REG != 0) && (resv_addr == '0));
    busy_wr  = busy_q;
    if (wr_eff) busy_wr[wr_addr] = 1'b0;
    accept   = resv_eff && !busy_wr[resv_addr];
    refuse   = resv_eff && busy_wr[resv_addr];
    clear    = wr_eff && busy_q[wr_addr];
    busy_d   = busy_wr;
    if (accept) busy_d[resv_addr] = 1'b1;
    cnt_d    = cnt_q + {{ADDR_W{1'b0}}, accept} - {{ADDR_W{1'b0}}, clear};
    err_d    = err_q | refuse;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy_1      = busy_q[rd_addr_1];
  assign busy_2      = busy_q[rd_addr_2];
  assign resv_stall  = busy_q[resv_addr] && !(wr_eff && (wr_addr == resv_addr));
  assign pending_cnt = cnt_q;
  assign resv_err    = err_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with write-through bypass and a busy-bit
// scoreboard for destinations of multi-cycle producers.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int BIT_SIZE = BIT_SIZE_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   Read_addr_1,
  input  logic [ADDR_W-1:0]   Read_addr_2,
  output logic [BIT_SIZE-1:0] Read_data_1,
  output logic [BIT_SIZE-1:0] Read_data_2,
  output logic                Read_busy_1,
  output logic                Read_busy_2,
  input  logic                Resv_valid,
  input  logic [ADDR_W-1:0]   Resv_addr,
  output logic                Resv_stall,
  input  logic                RegWrite,
  input  logic [ADDR_W-1:0]   Write_addr,
  input  logic [BIT_SIZE-1:0] Write_data,
  output logic [ADDR_W:0]     Pending_cnt,
  output logic                Resv_err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [BIT_SIZE-1:0] mem_q [DEPTH];
  logic [BIT_SIZE-1:0] mem_d [DEPTH];
  logic                wr_eff, hit_1, hit_2, zero_1, zero_2;
  logic                sb_busy_1, sb_busy_2;

  always_comb begin
    wr_eff = RegWrite && !((ZERO_REG != 0) && (Write_addr == '0));
    mem_d  = mem_q;
    if (wr_eff) mem_d[Write_addr] = Write_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  // Entry 0 is forced to zero and excluded from bypass when hardwired.
  always_comb begin
    zero_1      = (ZERO_REG != 0) && (Read_addr_1 == '0);
    zero_2      = (ZERO_REG != 0) && (Read_addr_2 == '0);
    hit_1       = wr_eff && (Write_addr == Read_addr_1);
    hit_2       = wr_eff && (Write_addr == Read_addr_2);
    Read_data_1 = zero_1 ? '0 : (hit_1 ? Write_data : mem_q[Read_addr_1]);
    Read_data_2 = zero_2 ? '0 : (hit_2 ? Write_data : mem_q[Read_addr_2]);
    Read_busy_1 = sb_busy_1 && !hit_1;
    Read_busy_2 = sb_busy_2 && !hit_2;
  end

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (RegWrite),
    .wr_addr    (Write_addr),
    .resv_valid (Resv_valid),
    .resv_addr  (Resv_addr),
    .rd_addr_1  (Read_addr_1),
    .rd_addr_2  (Read_addr_2),
    .busy_1     (sb_busy_1),
    .busy_2     (sb_busy_2),
    .resv_stall (Resv_stall),
    .pending_cnt(Pending_cnt),
    .resv_err   (Resv_err)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Scenario bench for regfile_sb: expected outputs are queued as stimulus is
// applied and compared once the combinational outputs settle.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  Read_addr_1, Read_addr_2, Resv_addr, Write_addr;
  logic [31:0] Read_data_1, Read_data_2, Write_data;
  logic        Read_busy_1, Read_busy_2, Resv_valid, Resv_stall, RegWrite, Resv_err;
  logic [5:0]  Pending_cnt;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic        st;
    logic [5:0]  cnt;
    logic        err;
  } obs_t;

  obs_t exp_q [$];
  obs_t obs, expv;
  int   tests_run = 0;
  int   tests_failed = 0;

  regfile_sb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Read_addr_1(Read_addr_1),
    .Read_addr_2(Read_addr_2),
    .Read_data_1(Read_data_1),
    .Read_data_2(Read_data_2),
    .Read_busy_1(Read_busy_1),
    .Read_busy_2(Read_busy_2),
    .Resv_valid (Resv_valid),
    .Resv_addr  (Resv_addr),
    .Resv_stall (Resv_stall),
    .RegWrite   (RegWrite),
    .Write_addr (Write_addr),
    .Write_data (Write_data),
    .Pending_cnt(Pending_cnt),
    .Resv_err   (Resv_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [31:0] d1, input logic [31:0] d2, input logic b1,
                              input logic b2, input logic st, input int cnt, input logic err);
    mk = '{d1: d1, d2: d2, b1: b1, b2: b2, st: st, cnt: cnt[5:0], err: err};
  endfunction

  function automatic obs_t sample();
    sample = '{d1: Read_data_1, d2: Read_data_2, b1: Read_busy_1, b2: Read_busy_2,
               st: Resv_stall, cnt: Pending_cnt, err: Resv_err};
  endfunction

  function automatic string fmt(input obs_t o);
    fmt = $sformatf("d1=%h d2=%h b1=%b b2=%b stall=%b cnt=%0d err=%b",
                    o.d1, o.d2, o.b1, o.b2, o.st, o.cnt, o.err);
  endfunction

  task automatic set_in(input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                        input logic rv, input logic [4:0] ra,
                        input logic [4:0] a1, input logic [4:0] a2);
    RegWrite = rw; Write_addr = wa; Write_data = wd;
    Resv_valid = rv; Resv_addr = ra;
    Read_addr_1 = a1; Read_addr_2 = a2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 5, 7);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    #1;
    obs = sample(); expv = exp_q.pop_front(); tests_run++;
    if (obs !== expv) begin tests_failed++; $display("[TB] FAIL reset: got %s, want %s", fmt(obs), fmt(expv)); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      if (s == 0) set_in(1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
      else        set_in(0, 0, 0, 0, 0, 5, 5);
      exp_q.push_back(mk(32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0, 0));
      #1;
      obs = sample(); expv = exp_q.pop_front(); tests_run++;
      if (obs !== expv) begin tests_failed++; $display("[TB] FAIL write_read step %0d: got %s, want %s", s, fmt(obs), fmt(expv)); end
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    set_in(1, 7, 32'h12345678, 0, 0, 7, 5);
    exp_q.push_back(mk(32'h12345678, 32'hDEADBEEF, 0, 0, 0, 0, 0));
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 7, 7);
    exp_q.push_back(mk(32'h12345678, 32'h12345678, 0, 0, 0, 0, 0));
    #1;
    obs = sample(); expv = exp_q.pop_back(); tests_run++;
    if (obs !== expv) begin tests_failed++; $display("[TB] FAIL bypass stored: got %s, want %s", fmt(obs), fmt(expv)); end
  endtask

  task automatic test_bypass_same_cycle();
    @(negedge clk);
    set_in(1, 7, 32'h0BADF00D, 0, 0, 7, 5);
    exp_q.push_back(mk(32'h0BADF00D, 32'hDEADBEEF, 0, 0, 0, 0, 0));
    #1;
    obs = sample(); expv = exp_q.pop_back(); tests_run++;
    if (obs !== expv) begin tests_failed++; $display("[TB] FAIL bypass same cycle: got %s, want %s", fmt(obs), fmt(expv)); end
    @(negedge clk);
    set_in(1, 7, 32'h12345678, 0, 0, 7, 7);
    exp_q.push_back(mk(32'h12345678, 32'h12345678, 0, 0, 0, 0, 0));
    #1;
    obs = sample(); expv = exp_q.pop_back(); tests_run++;
    if (obs !== expv) begin tests_failed++; $display("[TB] FAIL bypass rewrite: got %s, want %s", fmt(obs), fmt(expv)); end
    exp_q.delete();
  endtask

  task automatic test_zero_reg();
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      if (s == 0) begin
        set_in(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      end else begin
        set_in(0, 0, 0, 0, 0, 0, 5);
        exp_q.push_back(mk(0, 32'hDEADBEEF, 0, 0, 0, 0, 0));
      end
      #1;
      obs = sample(); expv = exp_q.pop_front(); tests_run++;
      if (obs !== expv) begin tests_failed++; $display("[TB] FAIL zero_reg step %0d: got %s, want %s", s, fmt(obs), fmt(expv)); end
    end
  endtask

  task automatic test_reserve();
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      case (s)
        0: begin set_in(1'b0, 0, 0, 1'b1, 3, 3, 7); exp_q.push_back(mk(0, 32'h12345678, 0, 0, 0, 0, 0)); end
        1: begin set_in(1'b0, 0, 0, 1'b0, 3, 3, 3); exp_q.push_back(mk(0, 0, 1, 1, 1, 1, 0)); end
        2: begin set_in(1'b1, 3, 5, 1'b0, 3, 3, 7); exp_q.push_back(mk(5, 32'h12345678, 0, 0, 0, 1, 0)); end
        default: begin set_in(1'b0, 0, 0, 1'b0, 3, 3, 3); exp_q.push_back(mk(5, 5, 0, 0, 0, 0, 0)); end
      endcase
      #1;
      obs = sample(); expv = exp_q.pop_front(); tests_run++;
      if (obs !== expv) begin tests_failed++; $display("[TB] FAIL reserve step %0d: got %s, want %s", s, fmt(obs), fmt(expv)); end
    end
  endtask

  task automatic test_write_reserve_same();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      case (s)
        0: begin set_in(1'b0, 0, 0, 1'b1, 4, 4, 3); exp_q.push_back(mk(0, 5, 0, 0, 0, 0, 0)); end
        1: begin set_in(1'b1, 4, 32'hAA, 1'b1, 4, 4, 4); exp_q.push_back(mk(32'hAA, 32'hAA, 0, 0, 0, 1, 0)); end
        2: begin set_in(1'b0, 0, 0, 1'b0, 4, 4, 3); exp_q.push_back(mk(32'hAA, 5, 1, 0, 1, 1, 0)); end
        3: begin set_in(1'b1, 4, 32'hBB, 1'b0, 4, 3, 4); exp_q.push_back(mk(5, 32'hBB, 0, 0, 0, 1, 0)); end
        default: begin set_in(1'b0, 0, 0, 1'b0, 4, 4, 4); exp_q.push_back(mk(32'hBB, 32'hBB, 0, 0, 0, 0, 0)); end
      endcase
      #1;
      obs = sample(); expv = exp_q.pop_front(); tests_run++;
      if (obs !== expv) begin tests_failed++; $display("[TB] FAIL write_reserve_same step %0d: got %s, want %s", s, fmt(obs), fmt(expv)); end
    end
  endtask

  task automatic test_double_reserve();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      case (s)
        0: begin set_in(1'b0, 0, 0, 1'b1, 3, 3, 4); exp_q.push_back(mk(5, 32'hBB, 0, 0, 0, 0, 0)); end
        1: begin set_in(1'b0, 0, 0, 1'b1, 3, 3, 3); exp_q.push_back(mk(5, 5, 1, 1, 1, 1, 0)); end
        2: begin set_in(1'b0, 0, 0, 1'b0, 3, 3, 4); exp_q.push_back(mk(5, 32'hBB, 1, 0, 1, 1, 1)); end
        3: begin set_in(1'b1, 3, 6, 1'b0, 3, 3, 3); exp_q.push_back(mk(6, 6, 0, 0, 0, 1, 1)); end
        default: begin set_in(1'b0, 0, 0, 1'b0, 3, 3, 3); exp_q.push_back(mk(6, 6, 0, 0, 0, 0, 1)); end
      endcase
      #1;
      obs = sample(); expv = exp_q.pop_front(); tests_run++;
      if (obs !== expv) begin tests_failed++; $display("[TB] FAIL double_reserve step %0d: got %s, want %s", s, fmt(obs), fmt(expv)); end
    end
  endtask

  task automatic test_mid_reset();
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      case (s)
        0: begin set_in(1'b0, 0, 0, 1'b1, 1, 1, 2); exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1)); end
        1: begin set_in(1'b0, 0, 0, 1'b1, 2, 1, 2); exp_q.push_back(mk(0, 0, 1, 0, 0, 1, 1)); end
        2: begin set_in(1'b0, 0, 0, 1'b1, 3, 1, 2); exp_q.push_back(mk(0, 0, 1, 1, 0, 2, 1)); end
        default: begin set_in(1'b0, 0, 0, 1'b0, 3, 3, 5); exp_q.push_back(mk(6, 32'hDEADBEEF, 1, 0, 1, 3, 1)); end
      endcase
      #1;
      obs = sample(); expv = exp_q.pop_front(); tests_run++;
      if (obs !== expv) begin tests_failed++; $display("[TB] FAIL mid_reset fill %0d: got %s, want %s", s, fmt(obs), fmt(expv)); end
    end
    #2;
    rst_n = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    #1;
    obs = sample(); expv = exp_q.pop_front(); tests_run++;
    if (obs !== expv) begin tests_failed++; $display("[TB] FAIL mid_reset async clear: got %s, want %s", fmt(obs), fmt(expv)); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      if (s == 0) begin
        set_in(1'b0, 0, 0, 1'b1, 1, 1, 7);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      end else begin
        set_in(1'b0, 0, 0, 1'b0, 1, 1, 7);
        exp_q.push_back(mk(0, 0, 1, 0, 1, 1, 0));
      end
      #1;
      obs = sample(); expv = exp_q.pop_front(); tests_run++;
      if (obs !== expv) begin tests_failed++; $display("[TB] FAIL mid_reset fresh %0d: got %s, want %s", s, fmt(obs), fmt(expv)); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_bypass_same_cycle();
    test_zero_reg();
    test_reserve();
    test_write_reserve_same();
    test_double_reserve();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter BIT_SIZE, default 32, data word width.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning: 1 hardwires entry 0 to zero, never busy.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Read_addr_1, Read_addr_2  input  ADDR_W  read port addresses (Rs, Rt).
REQ-007 Read_data_1, Read_data_2  output  BIT_SIZE  read data, combinational.
REQ-008 Read_busy_1, Read_busy_2  output  1  addressed entry has an outstanding reservation.
REQ-009 Resv_valid  input  1  reserve destination Resv_addr this cycle (issue of a multi-cycle producer).
REQ-010 Resv_addr  input  ADDR_W  entry to reserve.
REQ-011 Resv_stall  output  1  Resv_addr currently busy; a reservation would be refused.
REQ-012 RegWrite  input  1  write enable.
REQ-013 Write_addr  input  ADDR_W  write address (WR).
REQ-014 Write_data  input  BIT_SIZE  write data (WD).
REQ-015 Pending_cnt  output  ADDR_W+1  number of busy entries.
REQ-016 Resv_err  output  1  sticky: a refused reservation occurred.

Function
REQ-017 Writes SHALL update entry Write_addr at posedge when RegWrite=1; write clears busy bit of that entry.
REQ-018 Reads SHALL be combinational with write-through bypass: if RegWrite=1 and Write_addr equals a read address, that port returns Write_data and its busy output is 0 in the same cycle.
REQ-019 Read_busy_n SHALL equal busy[Read_addr_n] AND NOT(bypass hit on that port).
REQ-020 Resv_valid=1 with busy[Resv_addr]=0 (after same-cycle write clear) SHALL set busy[Resv_addr] at posedge; visible on next cycle.
REQ-021 Resv_valid=1 with Resv_addr busy and not being written this cycle SHALL be refused: busy unchanged, Resv_err set at posedge, held until reset.
REQ-022 Simultaneous write and reservation of the same entry SHALL leave busy=1 and store Write_data (write retires old producer, new reservation takes effect).
REQ-023 Write to a non-busy entry SHALL be a plain write; busy stays 0.
REQ-024 Pending_cnt SHALL track population of busy bits exactly: +1 on accepted reservation, -1 on write clearing a busy entry, unchanged when both affect the same entry; never wraps (max 2**ADDR_W).
REQ-025 With ZERO_REG=1, entry 0 SHALL read 0, never bypass, ignore writes and reservations (no error, no count change), busy outputs 0.
REQ-026 Resv_stall SHALL equal busy[Resv_addr] AND NOT(same-cycle write to Resv_addr); 0 for entry 0 when ZERO_REG=1.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear all data entries to 0, all busy bits, Pending_cnt and Resv_err; outputs become 0 immediately.
REQ-028 Reset asserted mid-operation SHALL discard outstanding reservations; first posedge after deassertion behaves as fresh state.

Structure
REQ-029 BIT_SIZE and ADDR_W defaults SHALL live in shared package regfile_pkg.
REQ-030 Busy bits, Pending_cnt and Resv_err SHALL be one sub-module, reg_scoreboard; data array and bypass stay in regfile_sb.

Verification
REQ-031 Reset, write 0xDEADBEEF to r5, read r5 both ports next cycle -> 0xDEADBEEF on both, busy 0.
REQ-032 Same cycle RegWrite r7=0x12345678 and Read_addr_1=7 -> Read_data_1=0x12345678 that cycle.
REQ-033 Reserve r3, next cycle read r3 -> Read_busy_1=1, Pending_cnt=1; write r3=0x5 -> busy 0, Pending_cnt=0 next cycle.
REQ-034 Reserve r3 twice without write -> second refused, Resv_err=1, Pending_cnt=1.
REQ-035 Write r0=0xFFFFFFFF and reserve r0 (ZERO_REG=1) -> read r0=0, busy 0, Pending_cnt=0, Resv_err=0.
REQ-036 Reserve r1,r2,r3, pulse rst_n low mid-cycle -> all data 0, Pending_cnt=0, busy 0 without clock edge.
